// File: rtl/punc_mmio_responder.sv
// PUnC memory-side responder: main RAM with fixed access latency plus
// LC3 keyboard/display device registers, one request in flight at a time.
module punc_mmio_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_overrun
);

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;
    localparam logic [3:0]  CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic                 dev_q, dev_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [15:0]          dev_rdata_q, dev_rdata_d;
    logic                 kbsr15_q, kbsr15_d;
    logic                 kbsr14_q, kbsr14_d;
    logic [7:0]           kbdr_q, kbdr_d;
    logic                 dsr15_q, dsr15_d;
    logic                 disp_valid_q, disp_valid_d;
    logic [7:0]           disp_data_q, disp_data_d;

    logic [15:0] mem_q [2**ADDR_BITS];
    logic [15:0] ram_rdata_q;
    logic        ram_go;

    logic        accept;
    logic        is_dev;
    logic        kbdr_rd;
    logic        ddr_wr;
    logic [15:0] dev_rd_val;

    // Device side effects happen on the accept edge, not in RESP.
    assign accept  = (state_q == IDLE) && req_valid;
    assign is_dev  = req_addr >= KBSR;
    assign kbdr_rd = accept && !req_we && (req_addr == KBDR);
    assign ddr_wr  = accept && req_we && (req_addr == DDR) && dsr15_q;

    // Device register read mux, sampled from the current register state.
    always_comb begin
        dev_rd_val = 16'h0000;
        unique case (1'b1)
            (req_addr == KBSR): dev_rd_val = {kbsr15_q, kbsr14_q, 14'b0};
            (req_addr == KBDR): dev_rd_val = {8'b0, kbdr_q};
            (req_addr == DSR):  dev_rd_val = {dsr15_q, 15'b0};
            default:            dev_rd_val = 16'h0000;
        endcase
    end

    // Next-state for the request FSM and the device registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        dev_d        = dev_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        dev_rdata_d  = dev_rdata_q;
        kbsr15_d     = kbsr15_q;
        kbsr14_d     = kbsr14_q;
        kbdr_d       = kbdr_q;
        dsr15_d      = dsr15_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        ram_go       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    dev_d   = is_dev;
                    idx_d   = req_addr[ADDR_BITS-1:0];
                    wdata_d = req_wdata;
                    if (is_dev) begin
                        state_d     = RESP;
                        dev_rdata_d = req_we ? 16'h0000 : dev_rd_val;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    ram_go  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (disp_valid_q && disp_ready) begin
            disp_valid_d = 1'b0;
            dsr15_d      = 1'b1;
        end

        // A KBDR read drains the keyboard; a same-cycle character refills it.
        if (kbdr_rd) begin
            kbsr15_d = 1'b0;
            kbsr14_d = 1'b0;
        end
        if (kb_valid) begin
            kbdr_d   = kb_data;
            kbsr15_d = 1'b1;
            if (kbsr15_q && !kbdr_rd) kbsr14_d = 1'b1;
        end

        if (ddr_wr) begin
            disp_data_d  = req_wdata[7:0];
            disp_valid_d = 1'b1;
            dsr15_d      = 1'b0;
        end
    end

    // State and device registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            dev_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 16'h0000;
            dev_rdata_q  <= 16'h0000;
            kbsr15_q     <= 1'b0;
            kbsr14_q     <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr15_q      <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            dev_q        <= dev_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            dev_rdata_q  <= dev_rdata_d;
            kbsr15_q     <= kbsr15_d;
            kbsr14_q     <= kbsr14_d;
            kbdr_q       <= kbdr_d;
            dsr15_q      <= dsr15_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    // RAM array; a reset in the final wait cycle cancels the access.
    always_ff @(posedge clk) begin
        if (ram_go && !rst) begin
            if (we_q) mem_q[idx_q] <= wdata_q;
            else      ram_rdata_q  <= mem_q[idx_q];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = (state_q != RESP) ? 16'h0000 :
                        dev_q             ? dev_rdata_q :
                        we_q              ? 16'h0000 : ram_rdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign kb_overrun = kbsr14_q;

endmodule

// File: tb/tb_punc_mmio_responder.sv
// Randomised bench for punc_mmio_responder against a flag-level model of
// the keyboard/display registers and a word array model of RAM.
module tb_punc_mmio_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    logic        kb_overrun;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_m [4096];
    bit          wr_m  [4096];
    bit          kb_full, kb_ovr, dpend;
    logic [7:0]  kb_chr, dchr;

    punc_mmio_responder #(
        .ADDR_BITS   (12),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .kb_overrun (kb_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kb_model(input logic [7:0] c);
        if (kb_full) kb_ovr = 1'b1;
        kb_full = 1'b1;
        kb_chr  = c;
    endtask

    task automatic model_reset();
        kb_full = 0;
        kb_ovr  = 0;
        kb_chr  = 8'h00;
        dpend   = 0;
        dchr    = 8'h00;
    endtask

    task automatic chk_out();
        chk("disp_valid", disp_valid, dpend);
        chk("disp_data", disp_data, dchr);
        chk("kb_overrun", kb_overrun, kb_ovr);
    endtask

    task automatic req(input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input bit kbw,
                       input logic [7:0] kbc,
                       output logic [15:0] rd, output int lat);
        int n;
        rd  = 16'h0000;
        lat = -1;
        n   = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        if (kbw) begin
            kb_valid = 1'b1;
            kb_data  = kbc;
        end
        step();
        req_valid = 1'b0;
        kb_valid  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                break;
            end
            step();
        end
        step();
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("rdata_idle", rsp_rdata, 0);
    endtask

    task automatic ram_wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] rd;
        int lat;
        req(1'b1, a, d, 1'b0, 8'h00, rd, lat);
        chk("ram_wr_lat", lat, 1 + LAT);
        chk("ram_wr_ack", rd, 0);
        mem_m[a[11:0]] = d;
        wr_m[a[11:0]]  = 1'b1;
    endtask

    task automatic ram_rd(input logic [15:0] a, output logic [15:0] rd);
        int lat;
        req(1'b0, a, 16'h0000, 1'b0, 8'h00, rd, lat);
        chk("ram_rd_lat", lat, 1 + LAT);
        if (wr_m[a[11:0]]) chk("ram_rd", rd, mem_m[a[11:0]]);
    endtask

    task automatic dev_rd(input logic [15:0] a, input bit kbw,
                          input logic [7:0] c, output logic [15:0] rd);
        logic [15:0] e;
        int lat;
        e = 16'h0000;
        if (a == 16'hFE00) begin
            e = {kb_full, kb_ovr, 14'b0};
        end else if (a == 16'hFE02) begin
            e       = {8'h00, kb_chr};
            kb_full = 0;
            kb_ovr  = 0;
        end else if (a == 16'hFE04) begin
            e = dpend ? 16'h0000 : 16'h8000;
        end
        req(1'b0, a, 16'h0000, kbw, c, rd, lat);
        chk("dev_rd_lat", lat, 1);
        chk("dev_rd", rd, e);
        if (kbw) kb_model(c);
        chk_out();
    endtask

    task automatic dev_wr(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] rd;
        int lat;
        req(1'b1, a, d, 1'b0, 8'h00, rd, lat);
        chk("dev_wr_lat", lat, 1);
        chk("dev_wr_ack", rd, 0);
        if (a == 16'hFE06 && !dpend) begin
            dpend = 1;
            dchr  = d[7:0];
        end
        chk_out();
    endtask

    task automatic kb_ev(input logic [7:0] c);
        kb_valid = 1'b1;
        kb_data  = c;
        step();
        kb_valid = 1'b0;
        kb_model(c);
        chk_out();
    endtask

    task automatic disp_acc();
        disp_ready = 1'b1;
        step();
        disp_ready = 1'b0;
        dpend = 0;
        chk_out();
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] a;
        int op;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        kb_valid   = 1'b0;
        kb_data    = 8'h00;
        disp_ready = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk_out();
        dev_rd(16'hFE00, 0, 8'h00, rd);
        dev_rd(16'hFE04, 0, 8'h00, rd);
        chk("rst_dsr", rd, 16'h8000);
        dev_rd(16'hFE02, 0, 8'h00, rd);

        ram_wr(16'h0040, 16'h1234);
        ram_rd(16'h0040, rd);
        chk("plan_ram", rd, 16'h1234);
        ram_wr(16'h1040, 16'hBEEF);
        ram_rd(16'h0040, rd);
        chk("plan_alias", rd, 16'hBEEF);

        kb_ev(8'h41);
        dev_rd(16'hFE00, 0, 8'h00, rd);
        chk("plan_kbsr_full", rd, 16'h8000);
        dev_rd(16'hFE02, 0, 8'h00, rd);
        chk("plan_kbdr", rd, 16'h0041);
        dev_rd(16'hFE00, 0, 8'h00, rd);
        chk("plan_kbsr_empty", rd, 16'h0000);

        kb_ev(8'h41);
        kb_ev(8'h42);
        chk("plan_overrun", kb_overrun, 1);
        dev_rd(16'hFE00, 0, 8'h00, rd);
        chk("plan_kbsr_ovr", rd, 16'hC000);
        dev_rd(16'hFE02, 0, 8'h00, rd);
        chk("plan_kbdr_ovr", rd, 16'h0042);

        dev_wr(16'hFE06, 16'h0058);
        chk("plan_disp_data", disp_data, 8'h58);
        dev_rd(16'hFE04, 0, 8'h00, rd);
        chk("plan_dsr_busy", rd, 16'h0000);
        dev_wr(16'hFE06, 16'h0059);
        chk("plan_disp_drop", disp_data, 8'h58);
        disp_acc();
        chk("plan_disp_done", disp_valid, 0);
        dev_rd(16'hFE04, 0, 8'h00, rd);
        chk("plan_dsr_ready", rd, 16'h8000);

        kb_ev(8'h31);
        dev_rd(16'hFE02, 1, 8'h33, rd);
        chk("plan_sim_old", rd, 16'h0031);
        dev_rd(16'hFE00, 0, 8'h00, rd);
        chk("plan_sim_kbsr", rd, 16'h8000);
        dev_rd(16'hFE02, 0, 8'h00, rd);
        chk("plan_sim_new", rd, 16'h0033);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 6);
            a  = {4'($urandom_range(0, 14)),
                  12'(12'h100 + 4 * $urandom_range(0, 7))};
            case (op)
                0: ram_wr(a, 16'($urandom));
                1: ram_rd(a, rd);
                2: kb_ev(8'($urandom));
                3: begin
                    case ($urandom_range(0, 5))
                        0: a = 16'hFE00;
                        1: a = 16'hFE02;
                        2: a = 16'hFE04;
                        3: a = 16'hFE06;
                        4: a = 16'hFE01;
                        default: a = 16'(16'hFE08 + $urandom_range(0, 16'h1F7));
                    endcase
                    dev_rd(a, $urandom_range(0, 3) == 0, 8'($urandom), rd);
                end
                4: dev_wr(16'hFE06, 16'($urandom));
                5: dev_wr($urandom_range(0, 1) ? 16'hFE02 : 16'hFE04,
                          16'($urandom));
                default: disp_acc();
            endcase
        end

        ram_wr(16'h0010, 16'h5555);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'hAAAA;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("midrst_ready", req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_rsp", rsp_valid, 0);
            step();
        end
        chk_out();
        ram_rd(16'h0010, rd);
        chk("midrst_kept", rd, 16'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
